// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder stage reused per clock, LSB first.
// start/done handshake; sum, cout and ovf update only when a result completes.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned    CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             load;
  logic             last;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] psum_next;

  // Next-state decode plus the single full-adder slice.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    last       = (cnt_q == LAST);
    s_bit      = a_q[0] ^ b_q[0] ^ carry_q;
    c_next     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    psum_next  = {s_bit, psum_q[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (last) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand shifters, carry, counter and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      busy <= (next_state == RUN);
      done <= (next_state == DONE);
      if (load) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub;
        cnt_q   <= '0;
      end else if (state == RUN) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        psum_q  <= psum_next;
        carry_q <= c_next;
        cnt_q   <= cnt_q + CNT_W'(1);
        // On the MSB slice, carry_q is the carry into the MSB.
        if (last) begin
          sum  <= psum_next;
          cout <= c_next;
          ovf  <= carry_q ^ c_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH 8, 2 and 16: per-cycle comparison against an
// arithmetic reference, plus directed cases with hand-computed results.
module tb_serial_add_sub;

  localparam int NI = 3;
  int wid [NI] = '{8, 2, 16};

  logic clk;

  logic        in_rst   [NI];
  logic        in_start [NI];
  logic        in_sub   [NI];
  logic [63:0] in_a     [NI];
  logic [63:0] in_b     [NI];
  logic [63:0] o_sum    [NI];
  logic        o_busy   [NI];
  logic        o_done   [NI];
  logic        o_cout   [NI];
  logic        o_ovf    [NI];

  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [15:0] sum16;
  logic        busy8, done8, cout8, ovf8;
  logic        busy2, done2, cout2, ovf2;
  logic        busy16, done16, cout16, ovf16;

  int n_chk = 0;
  int n_pass = 0;
  int acc_cnt [NI];
  int done_cnt [NI];

  serial_add_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(in_rst[0]), .start(in_start[0]), .sub(in_sub[0]),
    .a(in_a[0][7:0]), .b(in_b[0][7:0]),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_add_sub #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(in_rst[1]), .start(in_start[1]), .sub(in_sub[1]),
    .a(in_a[1][1:0]), .b(in_b[1][1:0]),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  serial_add_sub #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(in_rst[2]), .start(in_start[2]), .sub(in_sub[2]),
    .a(in_a[2][15:0]), .b(in_b[2][15:0]),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  assign o_sum[0] = 64'(sum8);
  assign o_sum[1] = 64'(sum2);
  assign o_sum[2] = 64'(sum16);
  assign o_busy[0] = busy8;
  assign o_busy[1] = busy2;
  assign o_busy[2] = busy16;
  assign o_done[0] = done8;
  assign o_done[1] = done2;
  assign o_done[2] = done16;
  assign o_cout[0] = cout8;
  assign o_cout[1] = cout2;
  assign o_cout[2] = cout16;
  assign o_ovf[0] = ovf8;
  assign o_ovf[1] = ovf2;
  assign o_ovf[2] = ovf16;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference arithmetic: returns {ovf, cout, sum}.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a_in,
                                         input logic [63:0] b_in, input logic s);
    logic [63:0] mask, a, b, r;
    logic [64:0] wide;
    logic        c, o, sa, sb, sr;
    mask = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
    a = a_in & mask;
    b = b_in & mask;
    if (s) begin
      r = (a - b) & mask;
      c = (a >= b);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      r = wide[63:0] & mask;
      c = ((wide >> w) != 65'd0);
    end
    sa = a[w-1];
    sb = b[w-1];
    sr = r[w-1];
    o = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {o, c, r};
  endfunction

  // Cycle-level reference: an op accepted at an edge completes WIDTH edges later.
  initial begin
    int          rem [NI];
    logic [65:0] pend [NI];
    logic [65:0] res [NI];
    logic        e_done [NI];
    logic        s_rst [NI], s_start [NI], s_sub [NI];
    logic [63:0] s_a [NI], s_b [NI];
    for (int i = 0; i < NI; i++) begin
      rem[i] = 0; pend[i] = '0; res[i] = '0; e_done[i] = 1'b0;
      acc_cnt[i] = 0; done_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        s_rst[i] = in_rst[i]; s_start[i] = in_start[i]; s_sub[i] = in_sub[i];
        s_a[i] = in_a[i]; s_b[i] = in_b[i];
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        e_done[i] = 1'b0;
        if (s_rst[i]) begin
          rem[i] = 0;
          res[i] = '0;
        end else if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            e_done[i] = 1'b1;
            res[i] = pend[i];
            done_cnt[i]++;
          end
        end else if (s_start[i]) begin
          rem[i] = wid[i];
          pend[i] = ref_op(wid[i], s_a[i], s_b[i], s_sub[i]);
          acc_cnt[i]++;
        end
        check($sformatf("w%0d_busy", wid[i]), 64'(o_busy[i]), 64'(rem[i] > 0));
        check($sformatf("w%0d_done", wid[i]), 64'(o_done[i]), 64'(e_done[i]));
        check($sformatf("w%0d_sum", wid[i]), o_sum[i], res[i][63:0]);
        check($sformatf("w%0d_cout", wid[i]), 64'(o_cout[i]), 64'(res[i][64]));
        check($sformatf("w%0d_ovf", wid[i]), 64'(o_ovf[i]), 64'(res[i][65]));
      end
    end
  end

  // Waits for done on the WIDTH=8 instance; lat counts edges after the accepting one.
  task automatic wait_done8(input string name, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen) check({name, "_done_timeout"}, 64'(done8), 64'd1);
  endtask

  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [7:0] e_sum, input logic e_cout,
                     input logic e_ovf);
    int lat;
    @(posedge clk); #1;
    in_a[0] = 64'(a); in_b[0] = 64'(b); in_sub[0] = s; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    in_a[0] = {$urandom, $urandom};
    in_b[0] = {$urandom, $urandom};
    in_sub[0] = 1'($urandom);
    wait_done8(name, lat);
    check({name, "_lat"}, 64'(lat), 64'd8);
    check({name, "_sum"}, 64'(sum8), 64'(e_sum));
    check({name, "_cout"}, 64'(cout8), 64'(e_cout));
    check({name, "_ovf"}, 64'(ovf8), 64'(e_ovf));
  endtask

  task automatic rand_run(input int i, input int n_ops);
    int target, cyc;
    target = acc_cnt[i] + n_ops;
    cyc = 0;
    while (acc_cnt[i] < target && cyc < 30000) begin
      @(posedge clk); #1;
      in_start[i] = ($urandom_range(0, 2) != 0);
      in_sub[i] = 1'($urandom);
      in_a[i] = {$urandom, $urandom};
      in_b[i] = {$urandom, $urandom};
      cyc++;
    end
    check($sformatf("w%0d_rand_accepts", wid[i]), 64'(acc_cnt[i] >= target), 64'd1);
    @(posedge clk); #1;
    in_start[i] = 1'b0;
    repeat (wid[i] + 3) @(posedge clk);
  endtask

  initial begin
    int lat, d0;
    for (int i = 0; i < NI; i++) begin
      in_rst[i] = 1'b1; in_start[i] = 1'b0; in_sub[i] = 1'b0;
      in_a[i] = '0; in_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) in_rst[i] = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_sum", 64'(sum8), 64'd0);

    op8("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

    // start during RUN is ignored
    @(posedge clk); #1;
    in_a[0] = 64'h12; in_b[0] = 64'h34; in_sub[0] = 1'b0; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    d0 = done_cnt[0];
    repeat (2) @(posedge clk);
    #1;
    in_a[0] = 64'hFF; in_b[0] = 64'hFF; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    wait_done8("ignore", lat);
    check("ignore_sum", 64'(sum8), 64'h46);
    repeat (12) @(posedge clk);
    check("ignore_one_done", 64'(done_cnt[0] - d0), 64'd1);
    check("ignore_idle_busy", 64'(busy8), 64'd0);

    // start asserted in DONE chains a second op
    @(posedge clk); #1;
    in_a[0] = 64'h35; in_b[0] = 64'h4A; in_sub[0] = 1'b0; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    wait_done8("chain1", lat);
    check("chain1_sum", 64'(sum8), 64'h7F);
    in_a[0] = 64'h10; in_b[0] = 64'h20; in_sub[0] = 1'b1; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    @(negedge clk);
    check("chain_busy", 64'(busy8), 64'd1);
    check("chain_done", 64'(done8), 64'd0);
    check("chain_held_sum", 64'(sum8), 64'h7F);
    wait_done8("chain2", lat);
    check("chain2_lat", 64'(lat), 64'd7);
    check("chain2_sum", 64'(sum8), 64'hF0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_hold_sum", 64'(sum8), 64'hF0);
      check("idle_hold_cout", 64'(cout8), 64'd0);
    end

    // reset mid-operation
    @(posedge clk); #1;
    in_a[0] = 64'hFF; in_b[0] = 64'h01; in_sub[0] = 1'b0; in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_rst[0] = 1'b1;
    @(posedge clk); #1;
    in_rst[0] = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_ovf", 64'(ovf8), 64'd0);
    d0 = done_cnt[0];
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) lat++;
    end
    check("rst_no_done", 64'(lat), 64'd0);
    check("rst_model_no_done", 64'(done_cnt[0] - d0), 64'd0);
    op8("post_rst", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

    rand_run(0, 200);
    rand_run(1, 1200);
    rand_run(2, 1200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
